// File: rtl/playback_controller.sv
// Purpose: play/pause/advance sequencing FSM with beat generator and elapsed-beat counter.
// Latency: all outputs registered; play/reset_player/song reflect a button one cycle after it is sampled.
// Backpressure: none; inputs are single-cycle pulses and are dropped while in ADVANCE.
// Optional feature macro: PLAYBACK_LOOP_ALL_EN (loop playlist after the last song).
module playback_controller #(
    parameter int NUM_SONGS  = 4,
    parameter int SONG_W     = 2,
    parameter int BEAT_COUNT = 1000,
    parameter int ELAPSED_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 play_button,
    input  logic                 next_button,
    input  logic                 song_done,
    output logic                 play,
    output logic                 reset_player,
    output logic [SONG_W-1:0]    song,
    output logic                 beat,
    output logic [ELAPSED_W-1:0] elapsed_beats
);

    localparam int CNT_W = (BEAT_COUNT > 1) ? $clog2(BEAT_COUNT) : 1;
    localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
    localparam logic [CNT_W-1:0]  BEAT_LAST = CNT_W'(BEAT_COUNT - 1);

`ifdef PLAYBACK_LOOP_ALL_EN
    localparam logic LOOP_ALL = 1'b1;
`else
    localparam logic LOOP_ALL = 1'b0;
`endif

    typedef enum logic [1:0] {
        PAUSED  = 2'd0,
        PLAYING = 2'd1,
        ADVANCE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             resume_q;    // ADVANCE exits to PLAYING when set
    logic             resume_nxt;
    logic [CNT_W-1:0] beat_cnt;

    // State register plus the remembered ADVANCE exit target
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= PAUSED;
            resume_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            resume_q <= resume_nxt;
        end
    end

    // Next-state logic: next_button beats song_done beats play_button
    always_comb begin
        state_nxt  = state;
        resume_nxt = resume_q;
        case (state)
            PAUSED, PLAYING: begin
                if (next_button) begin
                    state_nxt  = ADVANCE;
                    resume_nxt = 1'b0;
                end else if (song_done) begin
                    state_nxt  = ADVANCE;
                    resume_nxt = (song != LAST_SONG) || LOOP_ALL;
                end else if (play_button) begin
                    state_nxt = (state == PAUSED) ? PLAYING : PAUSED;
                end
            end
            ADVANCE: begin
                state_nxt = resume_q ? PLAYING : PAUSED;
            end
            default: begin
                state_nxt = PAUSED;
            end
        endcase
    end

    // play and reset_player track the state being entered so they line up with it
    always_ff @(posedge clk) begin
        if (reset) begin
            play         <= 1'b0;
            reset_player <= 1'b0;
        end else begin
            play         <= (state_nxt == PLAYING);
            reset_player <= (state_nxt == ADVANCE);
        end
    end

    // Song index steps (with wrap) when leaving ADVANCE
    always_ff @(posedge clk) begin
        if (reset) begin
            song <= '0;
        end else if (state == ADVANCE) begin
            song <= (song == LAST_SONG) ? '0 : song + SONG_W'(1);
        end
    end

    // Beat generator and saturating elapsed-beat counter; phase held while paused
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt      <= '0;
            beat          <= 1'b0;
            elapsed_beats <= '0;
        end else if (state == ADVANCE) begin
            beat_cnt      <= '0;
            beat          <= 1'b0;
            elapsed_beats <= '0;
        end else if (state == PLAYING) begin
            if (beat_cnt == BEAT_LAST) begin
                beat_cnt <= '0;
                beat     <= 1'b1;
                if (elapsed_beats != '1) begin
                    elapsed_beats <= elapsed_beats + ELAPSED_W'(1);
                end
            end else begin
                beat_cnt <= beat_cnt + CNT_W'(1);
                beat     <= 1'b0;
            end
        end else begin
            beat <= 1'b0;
        end
    end

endmodule

// File: tb/tb_playback_controller.sv
// Purpose: self-checking bench for playback_controller (table vectors + multi-cycle sequences).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus is one pulse per cycle.
module tb_playback_controller;

`ifdef PLAYBACK_LOOP_ALL_EN
    localparam logic LOOP = 1'b1;
`else
    localparam logic LOOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic play_button = 1'b0;
    logic next_button = 1'b0;
    logic song_done = 1'b0;

    logic        a_play, a_rp, a_beat;
    logic [1:0]  a_song;
    logic [15:0] a_elapsed;

    logic        s_play, s_rp, s_beat;
    logic [1:0]  s_song;
    logic [2:0]  s_elapsed;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    playback_controller u_dut (
        .clk           (clk),
        .reset         (rst),
        .play_button   (play_button),
        .next_button   (next_button),
        .song_done     (song_done),
        .play          (a_play),
        .reset_player  (a_rp),
        .song          (a_song),
        .beat          (a_beat),
        .elapsed_beats (a_elapsed)
    );

    playback_controller #(
        .BEAT_COUNT (2),
        .ELAPSED_W  (3)
    ) u_sat (
        .clk           (clk),
        .reset         (rst),
        .play_button   (play_button),
        .next_button   (next_button),
        .song_done     (song_done),
        .play          (s_play),
        .reset_player  (s_rp),
        .song          (s_song),
        .beat          (s_beat),
        .elapsed_beats (s_elapsed)
    );

    typedef struct {
        logic       rst;
        logic       pb;
        logic       nb;
        logic       sd;
        logic       e_play;
        logic       e_rp;
        logic [1:0] e_song;
    } vec_t;

    vec_t tbl[30];

    function automatic vec_t mk(input logic r, input logic pb, input logic nb, input logic sd,
                                input logic ep, input logic erp, input logic [1:0] es);
        vec_t v;
        v.rst = r; v.pb = pb; v.nb = nb; v.sd = sd;
        v.e_play = ep; v.e_rp = erp; v.e_song = es;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample just after the rising edge
    task automatic step(input logic r, input logic pb, input logic nb, input logic sd);
        rst = r; play_button = pb; next_button = nb; song_done = sd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Step idle until beat on the main DUT; returns cycle count or -1 on timeout
    task automatic wait_beat(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (a_beat) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int pause_beats;

        //              rst pb nb sd   play rp song
        tbl[0]  = mk(1, 0, 0, 0,  0, 0, 2'd0);
        tbl[1]  = mk(0, 0, 0, 0,  0, 0, 2'd0);
        tbl[2]  = mk(0, 1, 0, 0,  1, 0, 2'd0);
        tbl[3]  = mk(0, 0, 0, 0,  1, 0, 2'd0);
        tbl[4]  = mk(0, 0, 0, 1,  0, 1, 2'd0);
        tbl[5]  = mk(0, 0, 0, 0,  1, 0, 2'd1);
        tbl[6]  = mk(0, 0, 1, 0,  0, 1, 2'd1);
        tbl[7]  = mk(0, 0, 0, 0,  0, 0, 2'd2);
        tbl[8]  = mk(0, 1, 1, 0,  0, 1, 2'd2);
        tbl[9]  = mk(0, 0, 0, 0,  0, 0, 2'd3);
        tbl[10] = mk(0, 1, 0, 0,  1, 0, 2'd3);
        tbl[11] = mk(0, 0, 0, 1,  0, 1, 2'd3);
        tbl[12] = mk(0, 0, 0, 0,  LOOP, 0, 2'd0);
        tbl[13] = mk(0, 0, 0, 0,  LOOP, 0, 2'd0);
        tbl[14] = mk(0, 0, 1, 1,  0, 1, 2'd0);
        tbl[15] = mk(0, 0, 0, 0,  0, 0, 2'd1);
        tbl[16] = mk(0, 0, 0, 0,  0, 0, 2'd1);
        tbl[17] = mk(0, 0, 0, 1,  0, 1, 2'd1);
        tbl[18] = mk(0, 0, 0, 0,  1, 0, 2'd2);
        tbl[19] = mk(0, 0, 1, 0,  0, 1, 2'd2);
        tbl[20] = mk(0, 0, 0, 0,  0, 0, 2'd3);
        tbl[21] = mk(0, 1, 0, 0,  1, 0, 2'd3);
        tbl[22] = mk(0, 0, 1, 0,  0, 1, 2'd3);
        tbl[23] = mk(0, 0, 0, 0,  0, 0, 2'd0);
        tbl[24] = mk(0, 1, 0, 0,  1, 0, 2'd0);
        tbl[25] = mk(0, 0, 1, 0,  0, 1, 2'd0);
        tbl[26] = mk(0, 1, 0, 0,  0, 0, 2'd1);
        tbl[27] = mk(0, 1, 0, 0,  1, 0, 2'd1);
        tbl[28] = mk(0, 0, 1, 0,  0, 1, 2'd1);
        tbl[29] = mk(0, 0, 0, 0,  0, 0, 2'd2);

        // Table: FSM transitions, priorities and song wrap
        for (int i = 0; i < 30; i++) begin
            step(tbl[i].rst, tbl[i].pb, tbl[i].nb, tbl[i].sd);
            chk($sformatf("vec%0d_play", i), int'(a_play), int'(tbl[i].e_play));
            chk($sformatf("vec%0d_reset_player", i), int'(a_rp), int'(tbl[i].e_rp));
            chk($sformatf("vec%0d_song", i), int'(a_song), int'(tbl[i].e_song));
        end

        // Reset state and first beat timing
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_play", int'(a_play), 0);
        chk("rst_reset_player", int'(a_rp), 0);
        chk("rst_song", int'(a_song), 0);
        chk("rst_beat", int'(a_beat), 0);
        chk("rst_elapsed", int'(a_elapsed), 0);
        idle(8);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("start_play", int'(a_play), 1);
        wait_beat(1100, n);
        chk("first_beat_delay", n, 1000);
        chk("elapsed_after_1", int'(a_elapsed), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("beat_one_cycle", int'(a_beat), 0);
        wait_beat(1100, n);
        chk("second_beat_delay", n + 1, 1000);
        chk("elapsed_after_2", int'(a_elapsed), 2);

        // Pause/resume keeps phase: 400 playing, 500 paused, then 600 more to the beat
        idle(399);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("pause_play", int'(a_play), 0);
        pause_beats = 0;
        for (int i = 0; i < 499; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (a_beat) pause_beats++;
        end
        chk("beats_while_paused", pause_beats, 0);
        chk("elapsed_held_paused", int'(a_elapsed), 2);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("resume_play", int'(a_play), 1);
        wait_beat(1100, n);
        chk("resume_beat_delay", n, 600);
        chk("elapsed_after_3", int'(a_elapsed), 3);

        // next_button while playing clears elapsed and ends paused
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("next_reset_player", int'(a_rp), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("next_rp_done", int'(a_rp), 0);
        chk("next_song", int'(a_song), 1);
        chk("next_elapsed", int'(a_elapsed), 0);
        chk("next_play", int'(a_play), 0);

        // Saturation on the small instance
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("sat_play", int'(s_play), 1);
        idle(20);
        chk("sat_elapsed", int'(s_elapsed), 7);

        // Reset mid-song on song 2 aborts without a reset_player pulse
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("sat_song2", int'(s_song), 2);
        chk("sat_song2_play", int'(s_play), 1);
        idle(5);
        chk("sat_elapsed_nonzero", int'(s_elapsed != 3'd0), 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("midrst_play", int'(s_play), 0);
        chk("midrst_song", int'(s_song), 0);
        chk("midrst_elapsed", int'(s_elapsed), 0);
        chk("midrst_rp", int'(s_rp), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst_rp_after", int'(s_rp), 0);
        chk("midrst_play_after", int'(s_play), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
